// File: rtl/cpu_clk_pkg.sv
// Shared types for the CPU clock-enable sequencer: FSM state encodings and
// run-control command priorities (a higher cmd_e value wins).
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_STEP = 2'd1,
        CMD_RUN  = 2'd2,
        CMD_HALT = 2'd3
    } cmd_e;

    // Collapse the three same-cycle strobes to the single highest-priority command.
    function automatic cmd_e decode_cmd(input logic halt, input logic run, input logic step);
        if (halt)      return CMD_HALT;
        else if (run)  return CMD_RUN;
        else if (step) return CMD_STEP;
        else           return CMD_NONE;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Run-control command/status bundle for cpu_clk_ctrl.
// With CPU_CLK_CTRL_TICK_CNT_EN defined, a 32-bit tick_count status field is added.
interface cpu_clk_ctrl_if #(
    parameter int DIV_W = 16
);
    // Commands and div_load are single-cycle strobes sampled on clk; there is
    // no ready/backpressure, every strobe present at an edge is consumed there.
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             run;
    logic             halt;
    logic             step;
    logic             cpu_en;
    logic [1:0]       state;
    logic [DIV_W-1:0] div_active;
`ifdef CPU_CLK_CTRL_TICK_CNT_EN
    logic [31:0]      tick_count;

    modport master (output div_in, div_load, run, halt, step,
                    input  cpu_en, state, div_active, tick_count);
    modport slave  (input  div_in, div_load, run, halt, step,
                    output cpu_en, state, div_active, tick_count);
`else
    modport master (output div_in, div_load, run, halt, step,
                    input  cpu_en, state, div_active);
    modport slave  (input  div_in, div_load, run, halt, step,
                    output cpu_en, state, div_active);
`endif
endinterface

// File: rtl/clk_period_counter.sv
// Period counter for the clock-enable generator; wrap marks the last count
// (div-1) of the current period.
module clk_period_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             wrap
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign wrap = (cnt_q == (div - DIV_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (enable) cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/step sequencer producing a one-cycle CPU clock enable at a
// programmable period. Optional tick counter: CPU_CLK_CTRL_TICK_CNT_EN.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W         = 16,
    parameter int DEFAULT_DIV   = 2,
    parameter int START_RUNNING = 1
) (
    input  logic           clk,
    input  logic           reset,
    cpu_clk_ctrl_if.slave  bus
);

    localparam logic [DIV_W-1:0] RESET_DIV   = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);
    localparam state_e           RESET_STATE = (START_RUNNING != 0) ? ST_RUNNING : ST_HALTED;

    state_e           state_q, state_d;
    logic             cpu_en_q, tick_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             cnt_clear, cnt_enable, wrap;
    cmd_e             cmd;

    clk_period_counter #(.DIV_W(DIV_W)) u_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (cnt_enable),
        .clear  (cnt_clear),
        .div    (div_active_q),
        .wrap   (wrap)
    );

    assign cmd        = decode_cmd(bus.halt, bus.run, bus.step);
    assign cnt_enable = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);

    always_comb begin
        state_d   = state_q;
        tick_d    = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            ST_HALTED: begin
                cnt_clear = 1'b1;
                if (cmd == CMD_RUN)       state_d = ST_RUNNING;
                else if (cmd == CMD_STEP) state_d = ST_STEPPING;
            end
            ST_RUNNING: begin
                if (cmd == CMD_HALT) begin
                    state_d   = ST_HALTED;
                    cnt_clear = 1'b1;
                end else begin
                    tick_d = wrap;
                end
            end
            ST_STEPPING: begin
                // A run mid-step keeps the counter going so the period is not stretched.
                if (cmd == CMD_HALT) begin
                    state_d   = ST_HALTED;
                    cnt_clear = 1'b1;
                end else if (cmd == CMD_RUN) begin
                    state_d = ST_RUNNING;
                    tick_d  = wrap;
                end else if (wrap) begin
                    state_d = ST_HALTED;
                    tick_d  = 1'b1;
                end
            end
            default: begin
                state_d   = ST_HALTED;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // New ratios take effect only on a period boundary or while halted.
    always_comb begin
        div_pend_d = div_pend_q;
        if (bus.div_load) div_pend_d = (bus.div_in == '0) ? DIV_W'(1) : bus.div_in;
        div_active_d = div_active_q;
        if (tick_d || (state_q == ST_HALTED)) div_active_d = div_pend_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            cpu_en_q     <= 1'b0;
            div_active_q <= RESET_DIV;
            div_pend_q   <= RESET_DIV;
        end else begin
            state_q      <= state_d;
            cpu_en_q     <= tick_d;
            div_active_q <= div_active_d;
            div_pend_q   <= div_pend_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.cpu_en     = cpu_en_q;
    assign bus.div_active = div_active_q;

`ifdef CPU_CLK_CTRL_TICK_CNT_EN
    logic [31:0] tick_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       tick_cnt_q <= '0;
        else if (tick_d) tick_cnt_q <= tick_cnt_q + 32'd1;
    end

    assign bus.tick_count = tick_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: per-cycle expected {state, cpu_en, div_active}
// words are queued per scenario and compared one cycle at a time.
module tb_cpu_clk_ctrl;
    import cpu_clk_pkg::*;

    localparam int DIV_W = 16;
    localparam int W     = DIV_W + 3;

    logic clk = 1'b0;
    logic reset;

    cpu_clk_ctrl_if #(.DIV_W(DIV_W)) bus ();

    cpu_clk_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(2), .START_RUNNING(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;

    function automatic logic [W-1:0] pack(input int st, input int en, input int dv);
        return {st[1:0], en[0], dv[DIV_W-1:0]};
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.div_in   = '0;
        bus.div_load = 1'b0;
        bus.run      = 1'b0;
        bus.halt     = 1'b0;
        bus.step     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        act_v = {bus.state, bus.cpu_en, bus.div_active};
        n_checks++;
        if (act_v !== pack(ST_RUNNING, 0, 2)) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", act_v, pack(ST_RUNNING, 0, 2));
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) exp_q.push_back(pack(ST_RUNNING, (i % 2 == 0), 2));
        for (int i = 1; i <= 8; i++) begin
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_cadence cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
`ifdef CPU_CLK_CTRL_TICK_CNT_EN
        n_checks++;
        if (bus.tick_count !== 32'd4) begin
            n_fail++;
            $display("FAIL tick_count: got %0d expected 4", bus.tick_count);
        end
`endif
    endtask

    task automatic test_step();
        for (int i = 1; i <= 58; i++) begin
            if (i <= 2)      exp_q.push_back(pack(ST_HALTED, 0, 2));
            else if (i <= 7) exp_q.push_back(pack(ST_STEPPING, 0, 5));
            else if (i == 8) exp_q.push_back(pack(ST_HALTED, 1, 5));
            else             exp_q.push_back(pack(ST_HALTED, 0, 5));
        end
        for (int i = 1; i <= 58; i++) begin
            drive_idle();
            case (i)
                1: bus.halt = 1'b1;
                2: begin bus.div_load = 1'b1; bus.div_in = 16'd5; end
                3: bus.step = 1'b1;
                default: ;
            endcase
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL step cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_div_zero();
        for (int i = 1; i <= 13; i++) begin
            if (i == 1)      exp_q.push_back(pack(ST_HALTED, 0, 5));
            else if (i == 2) exp_q.push_back(pack(ST_HALTED, 0, 4));
            else if (i <= 6) exp_q.push_back(pack(ST_RUNNING, 0, 4));
            else             exp_q.push_back(pack(ST_RUNNING, 1, 1));
        end
        for (int i = 1; i <= 13; i++) begin
            drive_idle();
            case (i)
                1: begin bus.div_load = 1'b1; bus.div_in = 16'd4; end
                3: bus.run = 1'b1;
                5: begin bus.div_load = 1'b1; bus.div_in = 16'd0; end
                default: ;
            endcase
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL div_zero cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_halt_on_wrap();
        exp_q.push_back(pack(ST_RUNNING, 1, 1));
        exp_q.push_back(pack(ST_RUNNING, 1, 3));
        exp_q.push_back(pack(ST_RUNNING, 0, 3));
        exp_q.push_back(pack(ST_RUNNING, 0, 3));
        exp_q.push_back(pack(ST_HALTED, 0, 3));
        exp_q.push_back(pack(ST_RUNNING, 0, 3));
        exp_q.push_back(pack(ST_RUNNING, 0, 3));
        exp_q.push_back(pack(ST_RUNNING, 0, 3));
        exp_q.push_back(pack(ST_RUNNING, 1, 3));
        for (int i = 1; i <= 9; i++) begin
            drive_idle();
            case (i)
                1: begin bus.div_load = 1'b1; bus.div_in = 16'd3; end
                5: bus.halt = 1'b1;
                6: bus.run = 1'b1;
                default: ;
            endcase
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL halt_on_wrap cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_priority();
        for (int i = 1; i <= 10; i++) begin
            if (i <= 3)                exp_q.push_back(pack(ST_HALTED, 0, 3));
            else if (i == 7 || i == 10) exp_q.push_back(pack(ST_RUNNING, 1, 3));
            else                       exp_q.push_back(pack(ST_RUNNING, 0, 3));
        end
        for (int i = 1; i <= 10; i++) begin
            drive_idle();
            case (i)
                1: bus.halt = 1'b1;
                2: begin bus.halt = 1'b1; bus.run = 1'b1; bus.step = 1'b1; end
                4: begin bus.run = 1'b1; bus.step = 1'b1; end
                8: bus.step = 1'b1;
                9: bus.run = 1'b1;
                default: ;
            endcase
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL priority cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_last_load(output int b);
        int a;
        a = $urandom_range(2, 6);
        b = a + $urandom_range(1, 3);
        for (int i = 1; i <= 3 + b; i++) begin
            if (i <= 2)                  exp_q.push_back(pack(ST_RUNNING, 0, 3));
            else if (i == 3 || i == 3 + b) exp_q.push_back(pack(ST_RUNNING, 1, b));
            else                         exp_q.push_back(pack(ST_RUNNING, 0, b));
        end
        for (int i = 1; i <= 3 + b; i++) begin
            drive_idle();
            if (i == 1) begin bus.div_load = 1'b1; bus.div_in = a[DIV_W-1:0]; end
            if (i == 2) begin bus.div_load = 1'b1; bus.div_in = b[DIV_W-1:0]; end
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL last_load a=%0d b=%0d cyc %0d: got %h expected %h", a, b, i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_step_to_run(input int b);
        for (int i = 1; i <= 11; i++) begin
            if (i <= 2)                exp_q.push_back(pack(ST_HALTED, 0, b));
            else if (i <= 4)           exp_q.push_back(pack(ST_STEPPING, 0, 4));
            else if (i == 7 || i == 11) exp_q.push_back(pack(ST_RUNNING, 1, 4));
            else                       exp_q.push_back(pack(ST_RUNNING, 0, 4));
        end
        for (int i = 1; i <= 11; i++) begin
            drive_idle();
            case (i)
                1: bus.halt = 1'b1;
                2: begin bus.div_load = 1'b1; bus.div_in = 16'd4; end
                3: bus.step = 1'b1;
                5: bus.run = 1'b1;
                default: ;
            endcase
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL step_to_run cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 2)      exp_q.push_back(pack(ST_HALTED, 0, 4));
            else if (i == 3) exp_q.push_back(pack(ST_HALTED, 0, 8));
            else             exp_q.push_back(pack(ST_STEPPING, 0, 8));
        end
        for (int i = 1; i <= 6; i++) begin
            drive_idle();
            case (i)
                1: bus.halt = 1'b1;
                2: begin bus.div_load = 1'b1; bus.div_in = 16'd8; end
                4: bus.step = 1'b1;
                5: begin bus.div_load = 1'b1; bus.div_in = 16'd6; end
                default: ;
            endcase
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
        drive_idle();
        #3 reset = 1'b1;
        #1;
        act_v = {bus.state, bus.cpu_en, bus.div_active};
        n_checks++;
        if (act_v !== pack(ST_RUNNING, 0, 2)) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", act_v, pack(ST_RUNNING, 0, 2));
        end
`ifdef CPU_CLK_CTRL_TICK_CNT_EN
        n_checks++;
        if (bus.tick_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_tick_count: got %0d expected 0", bus.tick_count);
        end
`endif
        step_clk();
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) exp_q.push_back(pack(ST_RUNNING, (i % 2 == 0), 2));
        for (int i = 1; i <= 6; i++) begin
            step_clk();
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.cpu_en, bus.div_active};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    initial begin
        int b;
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_step();
        test_div_zero();
        test_halt_on_wrap();
        test_priority();
        test_last_load(b);
        test_step_to_run(b);
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run-control sequencer for the CPU core clock. It replaces free-running division of the board clock with a single-cycle clock-enable pulse, `cpu_en`. The pulse period is programmable at runtime. Run, halt and single-step commands come from the debug/button logic. The block sits between the board clock input and every CPU-core register enable, so the whole core stays in one clock domain.

## Interface
Parameters:
- `DIV_W`, 16: width of the divide ratio and period counter.
- `DEFAULT_DIV`, 2: divide ratio loaded at reset.
- `START_RUNNING`, 1: state after reset; 1 = RUNNING, 0 = HALTED.

Ports:
- `clk` input 1: board clock, sole clock.
- `reset` input 1: asynchronous, active-high reset.
- `div_in` input DIV_W: new divide ratio.
- `div_load` input 1: single-cycle strobe; captures `div_in`.
- `run` input 1: single-cycle command; enter RUNNING.
- `halt` input 1: single-cycle command; enter HALTED.
- `step` input 1: single-cycle command; emit exactly one tick from HALTED.
- `cpu_en` output 1: registered one-cycle clock enable for the CPU core.
- `state` output 2: current FSM state encoding.
- `div_active` output DIV_W: ratio currently in force, after zero-clamp.

## Operation
- FSM states and encodings:
  - HALTED = 0: no ticks; period counter held at 0.
  - RUNNING = 1: periodic ticks.
  - STEPPING = 2: one period, then return to HALTED.
- Command priority within one cycle: `halt` > `run` > `step`. Lower-priority commands in the same cycle are dropped.
- HALTED transitions:
  - `run`: go to RUNNING, counter = 0.
  - `step`: go to STEPPING, counter = 0.
- RUNNING transitions:
  - `halt`: go to HALTED immediately, counter = 0, no tick.
  - `run` and `step` are ignored.
- STEPPING transitions:
  - Counter wrap: emit a tick, go to HALTED.
  - `halt`: abort; no tick; go to HALTED.
  - `run`: go to RUNNING; counter continues without reset.
  - `step` is ignored.
- Period counter:
  - Counts 0 .. `div_active`−1 while RUNNING or STEPPING.
  - Wrap condition: counter == `div_active`−1.
  - At wrap, the next edge sets counter = 0 and `cpu_en` = 1 for exactly one cycle.
  - `cpu_en` is 0 in every other cycle.
- Divide ratio:
  - `div_load` captures `div_in` into a pending register.
  - The pending value is applied at the next wrap edge, or on the next edge if the state is HALTED.
  - Period changes are therefore glitch-free: the current period always completes at the old ratio.
  - `div_in` = 0 is clamped to 1, so `div_active` never reads 0.
  - Multiple loads before a boundary: the last one wins.
- `halt` in the same cycle as a wrap: halt wins, and no tick is emitted in the following cycle.

## Timing
- Reset values:
  - `cpu_en` = 0.
  - Counter = 0.
  - `div_active` = `DEFAULT_DIV` (clamped to 1 if 0); pending ratio = the same value.
  - `state` = RUNNING if `START_RUNNING`, else HALTED.
- Reset mid-operation: any in-flight step or pending ratio is discarded.
- Command latency: a command sampled at edge E0 changes `state` after E0.
- Tick latency: from a `run` sampled at E0 with ratio D, the first `cpu_en` is visible after edge E0+D. Subsequent ticks repeat every D cycles.
- D = 1: `cpu_en` is high every cycle from E0+1 onward.
- Step latency: `step` at E0 gives `cpu_en` after E0+D, and `state` = HALTED in that same cycle.
- Ratio change latency: `div_active` updates on the same edge that raises `cpu_en`, or one edge after `div_load` when HALTED.

## Configuration
- Macro `CPU_CLK_CTRL_TICK_CNT_EN`.
- When defined:
  - Adds output `tick_count`, 32 bits: number of `cpu_en` pulses since reset.
  - Increments on each `cpu_en` cycle and wraps 0xFFFFFFFF → 0.
  - Reset value 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Package `cpu_clk_pkg` holds:
  - State typedef and encodings (HALTED = 0, RUNNING = 1, STEPPING = 2; value 3 is unused and recovers to HALTED).
  - Command priority constants.
- Sub-module `clk_period_counter` (parameter DIV_W):
  - Inputs: `clk`, `reset`, `enable`, `clear`, `div`.
  - Output: `wrap` (combinational).
  - Owns the counter only.
- `cpu_clk_ctrl` owns the FSM, the pending-ratio logic and the `cpu_en` register.

## Test plan
- Reset with `START_RUNNING`=1, `DEFAULT_DIV`=2 → `cpu_en` pulses every 2nd cycle, first pulse 2 edges after reset release; `state` = 1.
- HALTED, `div_load` with `div_in`=5, then `step` → `div_active`=5 next cycle; exactly one `cpu_en` pulse 5 edges after `step`; `state` returns to 0; no further pulses over 50 cycles.
- RUNNING at D=4, `div_load` with `div_in`=0 mid-period → current period still completes at 4 cycles; `div_active`=1 at the wrap edge; `cpu_en` then high every cycle.
- RUNNING at D=3, `halt` asserted in the wrap cycle → no `cpu_en` in the next cycle; `state` = 0; counter = 0.
- Same-cycle `halt`+`run`+`step` while HALTED → stays HALTED; `run`+`step` together → RUNNING with the first tick after D edges.
- Reset asserted asynchronously mid-STEPPING at D=8 → `cpu_en` = 0 and state equals its reset value immediately, with no clock edge needed; pending ratio discarded. With `CPU_CLK_CTRL_TICK_CNT_EN` defined, `tick_count` returns to 0.
